// File: rtl/vga_debug_ram.sv
// Multi-channel byte-addressable shadow RAM for the VGA debug overlay.
// Byte-enable writes, per-entry dirty flags, 1-cycle lock-step reads, zero-fill sweep, drop counter.
module vga_debug_ram #(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned DEPTH  = 64,
    parameter int unsigned DATA_W = 32,
    localparam int unsigned NB     = DATA_W / 8,
    localparam int unsigned ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_CH-1:0]          wr_en,
    input  logic [NUM_CH*ADDR_W-1:0]   wr_addr,
    input  logic [NUM_CH*DATA_W-1:0]   wr_data,
    input  logic [NUM_CH*NB-1:0]       wr_be,
    input  logic                       rd_en,
    input  logic [ADDR_W-1:0]          rd_addr,
    output logic                       rd_valid,
    output logic [NUM_CH*DATA_W-1:0]   rd_data,
    output logic [NUM_CH-1:0]          rd_dirty,
    input  logic                       dirty_clr,
    input  logic                       clear_req,
    output logic                       busy,
    output logic [7:0]                 drop_cnt
);

    localparam logic [ADDR_W:0]   DEPTH_L  = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);

    typedef enum logic {ST_IDLE, ST_CLEAR} state_t;

    state_t                          r_state;
    logic [ADDR_W-1:0]               r_ptr;
    logic                            r_busy;
    logic [DATA_W-1:0]               r_mem [NUM_CH][DEPTH];
    logic [NUM_CH-1:0][DEPTH-1:0]    r_dirty;
    logic                            r_rd_valid;
    logic [NUM_CH*DATA_W-1:0]        r_rd_data;
    logic [NUM_CH-1:0]               r_rd_dirty;
    logic [7:0]                      r_drop_cnt;

    logic [ADDR_W-1:0]               w_wr_addr [NUM_CH];
    logic [NUM_CH-1:0]               w_wr_ok;
    logic [15:0]                     w_ndrop;
    logic [15:0]                     w_drop_sum;
    logic                            w_rd_in_range;

    // Per-channel write qualification and dropped-write tally for this cycle
    always_comb begin
        w_ndrop       = '0;
        w_wr_ok       = '0;
        w_rd_in_range = ({1'b0, rd_addr} < DEPTH_L);
        for (int c = 0; c < NUM_CH; c++) begin
            w_wr_addr[c] = wr_addr[c*ADDR_W +: ADDR_W];
            w_wr_ok[c]   = wr_en[c] && (r_state == ST_IDLE) && ({1'b0, w_wr_addr[c]} < DEPTH_L);
            w_ndrop      = w_ndrop + 16'(wr_en[c] && !w_wr_ok[c]);
        end
        w_drop_sum = 16'(r_drop_cnt) + w_ndrop;
    end

    // Storage array: sweep zero-fill or byte-lane merge; no reset so it maps to RAM
    always_ff @(posedge clk) begin
        for (int c = 0; c < NUM_CH; c++) begin
            if (r_state == ST_CLEAR) begin
                r_mem[c][r_ptr] <= '0;
            end else if (w_wr_ok[c]) begin
                for (int b = 0; b < NB; b++) begin
                    if (wr_be[c*NB + b])
                        r_mem[c][w_wr_addr[c]][8*b +: 8] <= wr_data[c*DATA_W + 8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_CLEAR;
            r_ptr      <= '0;
            r_busy     <= 1'b1;
            r_dirty    <= '0;
            r_rd_valid <= 1'b0;
            r_rd_data  <= '0;
            r_rd_dirty <= '0;
            r_drop_cnt <= '0;
        end else begin
            case (r_state)
                ST_CLEAR: begin
                    if (r_ptr == LAST_PTR) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                        r_ptr   <= '0;
                    end else begin
                        r_ptr <= r_ptr + ADDR_W'(1);
                    end
                end
                default: begin
                    if (clear_req) begin
                        r_state <= ST_CLEAR;
                        r_busy  <= 1'b1;
                        r_ptr   <= '0;
                    end
                end
            endcase

            // Later assignments win: a same-cycle write keeps its dirty flag set
            if (dirty_clr)
                r_dirty <= '0;
            for (int c = 0; c < NUM_CH; c++) begin
                if (r_state == ST_CLEAR)
                    r_dirty[c][r_ptr] <= 1'b0;
                if (w_wr_ok[c])
                    r_dirty[c][w_wr_addr[c]] <= 1'b1;
            end

            r_drop_cnt <= (w_drop_sum > 16'd255) ? 8'hFF : w_drop_sum[7:0];

            // Read-first: array and dirty values are sampled before this edge's updates land
            r_rd_valid <= rd_en;
            if (rd_en) begin
                if ((r_state == ST_CLEAR) || !w_rd_in_range) begin
                    r_rd_data  <= '0;
                    r_rd_dirty <= '0;
                end else begin
                    for (int c = 0; c < NUM_CH; c++) begin
                        r_rd_data[c*DATA_W +: DATA_W] <= r_mem[c][rd_addr];
                        r_rd_dirty[c]                 <= r_dirty[c][rd_addr];
                    end
                end
            end
        end
    end

    assign rd_valid = r_rd_valid;
    assign rd_data  = r_rd_data;
    assign rd_dirty = r_rd_dirty;
    assign busy     = r_busy;
    assign drop_cnt = r_drop_cnt;

endmodule
